// File: rtl/mem_nport_arb.sv
// mem_nport_arb: one byte-maskable single-bank RAM shared by NUM_PORTS
// requestors. A round-robin or fixed-priority arbiter grants at most one
// command per cycle. Reads return one cycle later on a shared data bus,
// and out-of-range accesses raise a one-cycle error pulse on the granted port.
module mem_nport_arb #(
    parameter int    NUM_PORTS  = 2,
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 4096,
    parameter int    ADDR_WIDTH = 32,
    parameter int    ARB_MODE   = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_PORTS-1:0]                cmd_valid,
    output logic [NUM_PORTS-1:0]                cmd_ready,
    input  logic [NUM_PORTS-1:0]                cmd_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] cmd_wmask,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic [NUM_PORTS-1:0]                rsp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Storage; contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Arbitration state and decisions
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      start_idx;
    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [NUM_PORTS-1:0]  grant;

    // Command of the granted port
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_word;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_oor;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BYTES-1:0]      sel_mask;
    logic                  wr_en;

    // Response registers
    logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0]  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Port index base+ofs wrapped into 0..NUM_PORTS-1 (ofs < NUM_PORTS).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PTR_W'(sum);
    endfunction

    // Arbiter: scan upward from the start index, first requesting port wins.
    always_comb begin
        start_idx = (ARB_MODE == 1) ? '0 : ptr_q;
        cand      = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = wrap_idx(start_idx, k);
            if (!gnt_any && cmd_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign cmd_ready = grant;

    // Round-robin pointer advance: the port after the winner gets first look next time.
    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE == 0) && gnt_any) begin
            ptr_d = wrap_idx(gnt_idx, 1);
        end
    end

    // Route the winning command and decode its word index / range.
    always_comb begin
        sel_addr  = cmd_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = cmd_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_mask  = cmd_wmask[int'(gnt_idx)*BYTES +: BYTES];
        sel_we    = cmd_we[gnt_idx];
        // Byte-offset bits are dropped; anything left above the index is out of range.
        sel_word  = sel_addr >> OFS_W;
        sel_idx   = sel_word[IDX_W-1:0];
        sel_oor   = |(sel_word >> IDX_W);
        wr_en     = gnt_any && sel_we && !sel_oor;
    end

    // RAM write port: masked byte update at the edge that accepts an in-range write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel_mask[b]) begin
                    mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response next-state: reads answer on the granted port, errors pulse for one cycle.
    always_comb begin
        rsp_valid_d = '0;
        rsp_err_d   = '0;
        rsp_data_d  = rsp_data_q;
        if (gnt_any) begin
            if (sel_oor) begin
                rsp_err_d = grant;
            end
            if (!sel_we) begin
                rsp_valid_d = grant;
                rsp_data_d  = sel_oor ? '0 : mem[sel_idx];
            end
        end
    end

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
